bnn_neuron_acc: RTL and testbench

Downstream consumer of the binarizer stage. Takes WIDTH binarized activations (±1, 2-bit signed) per beat, XNORs them against a WIDTH-bit weight word, and popcounts the matches. It accumulates the signed dot product over NUM_BEATS beats, adds a bias, and emits one signed depth-bit pre-activation. That result feeds the next binarizer.

---
 rtl/bnn_pkg.sv | 21 ++
 rtl/bnn_neuron_acc_if.sv | 28 ++
 rtl/bnn_xnor_popcount.sv | 29 ++
 rtl/bnn_neuron_acc.sv | 99 +++++++++
 tb/tb_bnn_neuron_acc.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bnn_pkg.sv
// Shared types and helpers for the binarized-neuron datapath.
// Activations are 2-bit signed codes whose sign bit alone selects +1 or -1.
package bnn_pkg;

   localparam int TARGET_DEPTH = 2;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } state_t;

   localparam logic signed [TARGET_DEPTH-1:0] ACT_POS = 2'sb01;
   localparam logic signed [TARGET_DEPTH-1:0] ACT_NEG = 2'sb11;

   // Non-canonical codes (00, 10) decode by the same sign-bit rule.
   function automatic logic act_sign(input logic signed [TARGET_DEPTH-1:0] act);
      return act[TARGET_DEPTH-1];
   endfunction

endpackage

// File: rtl/bnn_neuron_acc_if.sv
// Beat input and result output handshake bundle of the neuron accumulator.
// The master side feeds beats and consumes results; the slave side is the neuron.
interface bnn_neuron_acc_if #(
   parameter int WIDTH        = 3,
   parameter int depth        = 32,
   parameter int target_depth = 2
);

   logic                           in_valid;
   logic                           in_ready;
   logic signed [target_depth-1:0] in_act [WIDTH];
   logic        [WIDTH-1:0]        in_weight;
   logic signed [depth-1:0]        in_bias;
   logic                           out_valid;
   logic                           out_ready;
   logic signed [depth-1:0]        out_data;

   modport master (
      output in_valid, in_act, in_weight, in_bias, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_act, in_weight, in_bias, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/bnn_xnor_popcount.sv
// Combinational XNOR-popcount of one beat: term = 2*popcount(match) - WIDTH.
// A lane matches when activation and weight share the same polarity.
module bnn_xnor_popcount
   import bnn_pkg::*;
#(
   parameter int  WIDTH  = 3,
   localparam int TERM_W = $clog2(WIDTH) + 2
) (
   input  logic signed [TARGET_DEPTH-1:0] in_act_i [WIDTH],
   input  logic        [WIDTH-1:0]        in_weight_i,
   output logic signed [TERM_W-1:0]       term_o
);

   logic [WIDTH-1:0]  match;
   logic [TERM_W-1:0] popCnt;

   always_comb begin
      match  = '0;
      popCnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         match[i] = ~(act_sign(in_act_i[i]) ^ ~in_weight_i[i]);
         popCnt   = popCnt + TERM_W'(match[i]);
      end
   end

   // Modular arithmetic keeps the result exact over [-WIDTH, +WIDTH].
   assign term_o = $signed((popCnt << 1) - TERM_W'(WIDTH));

endmodule

// File: rtl/bnn_neuron_acc.sv
// Binarized neuron: accumulates NUM_BEATS XNOR-popcount terms onto a bias
// and presents one signed pre-activation per neuron.
module bnn_neuron_acc
   import bnn_pkg::*;
#(
   parameter int WIDTH        = 3,
   parameter int NUM_BEATS    = 4,
   parameter int depth        = 32,
   parameter int target_depth = TARGET_DEPTH
) (
   input logic              clk,
   input logic              rst_n,
   bnn_neuron_acc_if.slave  bus
);

   localparam int TERM_W = $clog2(WIDTH) + 2;
   localparam int CNT_W  = $clog2(NUM_BEATS) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BEATS - 1);

   if (NUM_BEATS < 1) begin : gBeatCountCheck
      $error("bnn_neuron_acc: NUM_BEATS must be at least 1");
   end
   if (longint'(NUM_BEATS) * longint'(WIDTH) >= (longint'(1) << (depth - 2))) begin : gRangeCheck
      $error("bnn_neuron_acc: NUM_BEATS*WIDTH must be below 2^(depth-2)");
   end
   if (target_depth != TARGET_DEPTH) begin : gActWidthCheck
      $error("bnn_neuron_acc: target_depth must match the package activation width");
   end

   state_t                  state_q, state_d;
   logic signed [depth-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]        beatCnt_q, beatCnt_d;
   logic signed [TERM_W-1:0] term;
   logic signed [depth-1:0] termExt;
   logic                    inReady;
   logic                    outValid;

   bnn_xnor_popcount #(.WIDTH(WIDTH)) uPopcount (
      .in_act_i    (bus.in_act),
      .in_weight_i (bus.in_weight),
      .term_o      (term)
   );

   assign termExt = {{(depth - TERM_W){term[TERM_W-1]}}, term};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         beatCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         beatCnt_q <= beatCnt_d;
      end
   end

   // in_ready is gated by rst_n so no beat looks accepted while held in reset.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      beatCnt_d = beatCnt_q;
      inReady   = 1'b0;
      outValid  = 1'b0;
      case (state_q)
         IDLE: begin
            inReady = rst_n;
            if (bus.in_valid && rst_n) begin
               acc_d     = bus.in_bias + termExt;
               beatCnt_d = CNT_W'(1);
               state_d   = (NUM_BEATS == 1) ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            inReady = rst_n;
            if (bus.in_valid && rst_n) begin
               acc_d     = acc_q + termExt;
               beatCnt_d = beatCnt_q + CNT_W'(1);
               if (beatCnt_q == LAST_CNT) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            outValid = 1'b1;
            if (bus.out_ready) begin
               state_d   = IDLE;
               beatCnt_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready  = inReady;
   assign bus.out_valid = outValid;
   assign bus.out_data  = acc_q;

endmodule

// File: tb/tb_bnn_neuron_acc.sv
// Scoreboard bench for bnn_neuron_acc: a reference model computes each neuron's
// sum from signed lane products, and a monitor compares every accepted result.
module tb_bnn_neuron_acc;
   import bnn_pkg::*;

   localparam int WIDTH     = 3;
   localparam int NUM_BEATS = 4;
   localparam int DEPTH     = 32;

   typedef logic [1:0] code_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   bnn_neuron_acc_if #(.WIDTH(WIDTH), .depth(DEPTH), .target_depth(2)) bus ();

   bnn_neuron_acc #(
      .WIDTH        (WIDTH),
      .NUM_BEATS    (NUM_BEATS),
      .depth        (DEPTH),
      .target_depth (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int compared   = 0;
   int mismatched = 0;
   int expQ[$];

   bit manualReady = 1'b1;
   bit readyVal    = 1'b1;

   code_t            nActs  [NUM_BEATS][WIDTH];
   logic [WIDTH-1:0] nWeight[NUM_BEATS];
   int               nBias  [NUM_BEATS];

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Reference: bias of beat 0 plus the sum of (+/-1 activation) * (+/-1 weight).
   function automatic int neuronExpected();
      int sum;
      sum = nBias[0];
      for (int b = 0; b < NUM_BEATS; b++) begin
         for (int i = 0; i < WIDTH; i++) begin
            int a, w;
            a = nActs[b][i][1] ? -1 : 1;
            w = nWeight[b][i] ? 1 : -1;
            sum += a * w;
         end
      end
      return sum;
   endfunction

   task automatic fillUniform(input code_t c0, input code_t c1, input code_t c2,
                              input logic [WIDTH-1:0] w, input int bias0, input int biasRest);
      for (int b = 0; b < NUM_BEATS; b++) begin
         nActs[b][0] = c0;
         nActs[b][1] = c1;
         nActs[b][2] = c2;
         nWeight[b]  = w;
         nBias[b]    = (b == 0) ? bias0 : biasRest;
      end
   endtask

   task automatic fillRandom();
      for (int b = 0; b < NUM_BEATS; b++) begin
         for (int i = 0; i < WIDTH; i++) nActs[b][i] = code_t'($urandom_range(3));
         nWeight[b] = WIDTH'($urandom_range(7));
         nBias[b]   = int'($urandom_range(2000)) - 1000;
      end
   endtask

   task automatic driveBeat(input int b);
      for (int i = 0; i < WIDTH; i++) bus.in_act[i] = nActs[b][i];
      bus.in_weight = nWeight[b];
      bus.in_bias   = nBias[b];
   endtask

   // Present beat b and return just after the rising edge that accepts it.
   task automatic applyStimulus(input int b);
      int  waited;
      logic rdy;
      waited = 0;
      @(negedge clk);
      driveBeat(b);
      bus.in_valid = 1'b1;
      forever begin
         #1;
         rdy = bus.in_ready;
         @(posedge clk);
         if (rdy) return;
         waited++;
         if (waited > 100) begin
            checkOutput("beat_accept_timeout", 0, 1);
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic dropValid();
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   // gapMode: 0 back-to-back, 1 one idle cycle between beats, 2 random gaps.
   task automatic runNeuron(input int gapMode);
      int expected;
      expected = neuronExpected();
      for (int b = 0; b < NUM_BEATS; b++) begin
         if (b > 0 && (gapMode == 1 || (gapMode == 2 && $urandom_range(2) == 0))) begin
            dropValid();
            #1;
            checkOutput("gap_no_valid", int'(bus.out_valid), 0);
         end
         applyStimulus(b);
         if (b == NUM_BEATS - 1) expQ.push_back(expected);
         #1;
         checkOutput(b == NUM_BEATS - 1 ? "valid_after_last" : "valid_before_last",
                     int'(bus.out_valid), (b == NUM_BEATS - 1) ? 1 : 0);
      end
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while (expQ.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (expQ.size() != 0) begin
         checkOutput("drain_timeout", expQ.size(), 0);
         expQ.delete();
      end
   endtask

   always @(negedge clk) begin
      bus.out_ready = manualReady ? readyVal : ($urandom_range(3) != 0);
   end

   // Monitor: a result is consumed on the rising edge following this sample.
   always @(negedge clk) begin
      #1;
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_result", int'(bus.out_data), 0);
            if (bus.out_data == 0) begin
               mismatched++;
               $display("[TB] FAIL unexpected_result: got out_valid=1, expected no result");
            end
         end else begin
            checkOutput("result", int'(bus.out_data), expQ.pop_front());
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin
      int expA;
      bus.in_valid  = 1'b0;
      bus.in_weight = '0;
      bus.in_bias   = '0;
      for (int i = 0; i < WIDTH; i++) bus.in_act[i] = '0;

      #1;
      checkOutput("reset_in_ready", int'(bus.in_ready), 0);
      checkOutput("reset_out_valid", int'(bus.out_valid), 0);
      checkOutput("reset_out_data", int'(bus.out_data), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("post_reset_in_ready", int'(bus.in_ready), 1);

      fillUniform(ACT_POS, ACT_POS, ACT_POS, 3'b111, 0, 0);
      runNeuron(0);
      fillUniform(ACT_NEG, ACT_NEG, ACT_NEG, 3'b111, 5, 99);
      runNeuron(0);
      fillUniform(ACT_POS, ACT_NEG, ACT_POS, 3'b101, 0, 0);
      runNeuron(0);
      fillUniform(ACT_POS, ACT_NEG, ACT_POS, 3'b010, 0, 0);
      runNeuron(0);
      fillUniform(2'b00, 2'b10, 2'b00, 3'b111, 0, 0);
      runNeuron(0);
      fillUniform(2'b10, 2'b10, 2'b10, 3'b000, 7, -50);
      runNeuron(0);
      dropValid();
      waitDrain();

      // Back-pressure: hold the result while the next neuron's first beat waits.
      readyVal = 1'b0;
      fillUniform(ACT_POS, ACT_POS, ACT_POS, 3'b111, 3, 3);
      expA = neuronExpected();
      runNeuron(0);
      fillUniform(ACT_POS, ACT_NEG, ACT_POS, 3'b101, -2, 40);
      @(negedge clk);
      driveBeat(0);
      bus.in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         checkOutput("hold_out_valid", int'(bus.out_valid), 1);
         checkOutput("hold_out_data", int'(bus.out_data), expA);
         checkOutput("hold_in_ready", int'(bus.in_ready), 0);
      end
      readyVal = 1'b1;
      runNeuron(0);
      dropValid();
      waitDrain();

      fillUniform(ACT_POS, ACT_NEG, ACT_POS, 3'b101, 1, 1);
      runNeuron(1);
      dropValid();
      waitDrain();

      // Reset mid-accumulation discards the partial sum and yields no result.
      fillUniform(ACT_POS, ACT_POS, ACT_POS, 3'b111, 20, 20);
      applyStimulus(0);
      applyStimulus(1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      checkOutput("mid_reset_out_valid", int'(bus.out_valid), 0);
      checkOutput("mid_reset_out_data", int'(bus.out_data), 0);
      checkOutput("mid_reset_in_ready", int'(bus.in_ready), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      fillUniform(ACT_NEG, ACT_POS, ACT_POS, 3'b011, -4, 8);
      runNeuron(0);
      dropValid();
      waitDrain();

      manualReady = 1'b0;
      for (int n = 0; n < 16; n++) begin
         fillRandom();
         runNeuron(2);
      end
      dropValid();
      manualReady = 1'b1;
      readyVal    = 1'b1;
      waitDrain();
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
